// File: rtl/matrix_pkg.sv
// Shared defaults and types for the HUB75 frame buffer: pixel geometry and the swap FSM state.
package matrix_pkg;

  localparam int DEF_DATA_WIDTH   = 16;  // RGB565
  localparam int DEF_ADDR_BITS    = 10;
  localparam int DEF_NUM_CHANNELS = 2;   // top / bottom panel halves
  localparam int DEF_CH_BITS      = 1;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/fb_bank_ram.sv
// One simple dual-port pixel bank holding both buffers of a single panel segment.
// The buffer index is the address MSB; the read port is registered and holds when not enabled.
module fb_bank_ram
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AW         = DEF_ADDR_BITS + 1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**AW];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: neither the array nor its read register is reset, so the pair maps onto a block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_ram.sv
// Double-buffered pixel store between the pixel writer and the HUB75 scanner.
// Writer fills the back buffer; swaps requested by the writer take effect only on frame_start.
module frame_buffer_ram
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_BITS    = DEF_ADDR_BITS,
  parameter int NUM_CHANNELS = DEF_NUM_CHANNELS,
  parameter int CH_BITS      = DEF_CH_BITS
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [CH_BITS+ADDR_BITS-1:0]       write_addr,
  input  logic [DATA_WIDTH-1:0]              write_data,
  input  logic                               write_en,
  input  logic                               swap_req,
  input  logic                               frame_start,
  input  logic [ADDR_BITS-1:0]               read_addr,
  input  logic                               read_en,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] read_data,
  output logic                               read_valid,
  output logic                               swap_pending,
  output logic                               swap_ack,
  output logic                               front_buffer
);

  swap_state_e state_q, state_d;
  logic        front_q, front_d;
  logic        swap_ack_q, swap_ack_d;
  logic        read_valid_q, read_valid_d;
  logic        rd_seen_q, rd_seen_d;

  logic [CH_BITS-1:0]                 wr_ch;
  logic [ADDR_BITS-1:0]               wr_pix;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] bank_rdata;

  assign wr_ch  = write_addr[ADDR_BITS +: CH_BITS];
  assign wr_pix = write_addr[ADDR_BITS-1:0];

  // Channels at or above NUM_CHANNELS match no bank, so their writes vanish.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_bank
    fb_bank_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .AW         (ADDR_BITS + 1)
    ) u_bank (
      .clk   (clk),
      .we    (write_en && (wr_ch == CH_BITS'(c))),
      .waddr ({~front_q, wr_pix}),
      .wdata (write_data),
      .re    (read_en),
      .raddr ({front_q, read_addr}),
      .rdata (bank_rdata[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    state_d      = state_q;
    front_d      = front_q;
    swap_ack_d   = 1'b0;
    read_valid_d = read_en;
    rd_seen_d    = rd_seen_q | read_en;
    case (state_q)
      SWAP_IDLE: begin
        if (swap_req && frame_start) begin
          front_d    = ~front_q;
          swap_ack_d = 1'b1;
        end else if (swap_req) begin
          state_d = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        // Repeated swap_req here is absorbed: one swap per request burst.
        if (frame_start) begin
          front_d    = ~front_q;
          swap_ack_d = 1'b1;
          state_d    = SWAP_IDLE;
        end
      end
      default: state_d = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SWAP_IDLE;
      front_q      <= 1'b0;
      swap_ack_q   <= 1'b0;
      read_valid_q <= 1'b0;
      rd_seen_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      swap_ack_q   <= swap_ack_d;
      read_valid_q <= read_valid_d;
      rd_seen_q    <= rd_seen_d;
    end
  end

  // The bank read registers carry no reset; read_data shows zero until the first read after reset.
  assign read_data    = rd_seen_q ? bank_rdata : '0;
  assign read_valid   = read_valid_q;
  assign swap_pending = (state_q == SWAP_PENDING);
  assign swap_ack     = swap_ack_q;
  assign front_buffer = front_q;

endmodule

// File: tb/tb_frame_buffer_ram.sv
// Self-checking bench: directed swap/reset scenarios plus random traffic against a buffer-level model.
module tb_frame_buffer_ram;

  localparam int DW  = 16;
  localparam int AB  = 10;
  localparam int NCH = 2;
  localparam int CB  = 1;
  localparam int AB3  = 4;
  localparam int NCH3 = 3;
  localparam int CB3  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [CB+AB-1:0]  write_addr;
  logic [DW-1:0]     write_data;
  logic              write_en, swap_req, frame_start, read_en;
  logic [AB-1:0]     read_addr;
  logic [NCH*DW-1:0] read_data;
  logic              read_valid, swap_pending, swap_ack, front_buffer;

  logic [CB3+AB3-1:0] w3_addr;
  logic [DW-1:0]      w3_data;
  logic               w3_en, w3_swap, w3_fs, r3_en;
  logic [AB3-1:0]     r3_addr;
  logic [NCH3*DW-1:0] r3_data;
  logic               r3_valid, s3_pending, s3_ack, f3_front;

  frame_buffer_ram #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_CHANNELS(NCH), .CH_BITS(CB)) dut (
    .clk(clk), .reset(reset), .write_addr(write_addr), .write_data(write_data),
    .write_en(write_en), .swap_req(swap_req), .frame_start(frame_start),
    .read_addr(read_addr), .read_en(read_en), .read_data(read_data),
    .read_valid(read_valid), .swap_pending(swap_pending), .swap_ack(swap_ack),
    .front_buffer(front_buffer)
  );

  frame_buffer_ram #(.DATA_WIDTH(DW), .ADDR_BITS(AB3), .NUM_CHANNELS(NCH3), .CH_BITS(CB3)) dut3 (
    .clk(clk), .reset(reset), .write_addr(w3_addr), .write_data(w3_data),
    .write_en(w3_en), .swap_req(w3_swap), .frame_start(w3_fs),
    .read_addr(r3_addr), .read_en(r3_en), .read_data(r3_data),
    .read_valid(r3_valid), .swap_pending(s3_pending), .swap_ack(s3_ack),
    .front_buffer(f3_front)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two buffers per channel, a front index and a pending-request flag.
  logic [DW-1:0] m_mem   [NCH][2][2**AB];
  bit            m_known [NCH][2][2**AB];
  bit            m_front, m_pending, m_ack, m_valid;
  logic [DW-1:0] m_data  [NCH];
  bit            m_dknown[NCH];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_front   <= 1'b0;
      m_pending <= 1'b0;
      m_ack     <= 1'b0;
      m_valid   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_data[c]   <= '0;
        m_dknown[c] <= 1'b1;
      end
    end else begin
      if (write_en && int'(write_addr[AB +: CB]) < NCH) begin
        m_mem[write_addr[AB +: CB]][!m_front][write_addr[AB-1:0]]   <= write_data;
        m_known[write_addr[AB +: CB]][!m_front][write_addr[AB-1:0]] <= 1'b1;
      end
      m_valid <= read_en;
      if (read_en) begin
        for (int c = 0; c < NCH; c++) begin
          m_data[c]   <= m_mem[c][m_front][read_addr];
          m_dknown[c] <= m_known[c][m_front][read_addr];
        end
      end
      m_ack <= 1'b0;
      if (frame_start && (m_pending || swap_req)) begin
        m_front   <= !m_front;
        m_pending <= 1'b0;
        m_ack     <= 1'b1;
      end else if (swap_req) begin
        m_pending <= 1'b1;
      end
    end
  end

  bit cmp_en    = 1'b0;
  int ack_count = 0;

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("read_valid", read_valid, m_valid);
      check("swap_pending", swap_pending, m_pending);
      check("swap_ack", swap_ack, m_ack);
      check("front_buffer", front_buffer, m_front);
      for (int c = 0; c < NCH; c++)
        if (m_dknown[c]) check("read_data", read_data[c*DW +: DW], m_data[c]);
      if (swap_ack) ack_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0; swap_req = 1'b0; frame_start = 1'b0; read_en = 1'b0;
    w3_en = 1'b0; w3_swap = 1'b0; w3_fs = 1'b0; r3_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] pat3(input int c, input int a);
    return DW'(16'h1000 * c + 16'h0011 * a + 7);
  endfunction

  initial begin
    int a0;
    logic [NCH3*DW-1:0] exp3;
    write_addr = '0; write_data = '0; read_addr = '0;
    w3_addr = '0; w3_data = '0; r3_addr = '0;
    idle();
    reset = 1'b0;
    #1 reset = 1'b1;
    #10;
    check("reset_front", front_buffer, 1'b0);
    check("reset_pending", swap_pending, 1'b0);
    check("reset_ack", swap_ack, 1'b0);
    check("reset_valid", read_valid, 1'b0);
    check("reset_data", read_data, '0);
    reset = 1'b0;
    tick();
    cmp_en = 1'b1;

    // First read: valid one cycle after read_en
    read_en = 1'b1; read_addr = '0;
    tick();
    read_en = 1'b0;
    check("first_read_valid", read_valid, 1'b1);
    tick();
    check("valid_drops", read_valid, 1'b0);

    // Fill back buffer, swap at frame boundary, read back
    a0 = ack_count;
    write_en = 1'b1; write_addr = {1'b0, 10'd5}; write_data = 16'hF800;
    tick();
    write_addr = {1'b1, 10'd5}; write_data = 16'h07E0;
    tick();
    write_en = 1'b0; swap_req = 1'b1;
    tick();
    swap_req = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0; read_en = 1'b1; read_addr = 10'd5;
    tick();
    read_en = 1'b0;
    check("swap_read_data", read_data, 32'h07E0_F800);
    check("swap_front", front_buffer, 1'b1);
    tick(); tick();
    check("swap_ack_once", ack_count - a0, 1);

    // Reset while a swap is pending: clears with no clock edge, RAM survives
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("pending_set", swap_pending, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_pending", swap_pending, 1'b0);
    check("async_front", front_buffer, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    tick();

    // swap_req and frame_start together: immediate toggle, ack next cycle
    swap_req = 1'b1; frame_start = 1'b1;
    tick();
    idle();
    check("same_cycle_front", front_buffer, 1'b1);
    check("same_cycle_pending", swap_pending, 1'b0);
    check("same_cycle_ack", swap_ack, 1'b1);
    tick();
    check("same_cycle_ack_drop", swap_ack, 1'b0);
    read_en = 1'b1; read_addr = 10'd5;
    tick();
    read_en = 1'b0;
    check("ram_after_reset", read_data, 32'h07E0_F800);

    // Request burst: one swap only
    a0 = ack_count;
    for (int i = 0; i < 3; i++) begin
      swap_req = 1'b1; tick();
      swap_req = 1'b0; tick();
    end
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick(); tick();
    check("burst_front", front_buffer, 1'b0);
    check("burst_ack_count", ack_count - a0, 1);

    // Long wait for frame boundary: pending holds, reads stay on old front
    swap_req = 1'b1; tick();
    swap_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      read_en = 1'b1; read_addr = AB'($urandom_range(0, 15));
      tick();
    end
    read_en = 1'b0;
    check("long_pending", swap_pending, 1'b1);
    check("long_front", front_buffer, 1'b0);
    frame_start = 1'b1; tick();
    frame_start = 1'b0; tick();
    check("long_swapped", front_buffer, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      write_en    = 1'($urandom_range(0, 1));
      write_addr  = {CB'($urandom_range(0, NCH - 1)), AB'($urandom_range(0, 15))};
      write_data  = DW'($urandom);
      read_en     = 1'($urandom_range(0, 1));
      read_addr   = AB'($urandom_range(0, 15));
      swap_req    = ($urandom_range(0, 19) == 0);
      frame_start = ($urandom_range(0, 29) == 0);
      tick();
    end
    idle();
    tick();

    // Three-channel instance: channel 3 writes must not reach any bank
    for (int c = 0; c < NCH3; c++) begin
      for (int a = 0; a < 16; a++) begin
        w3_en = 1'b1; w3_addr = {CB3'(c), AB3'(a)}; w3_data = pat3(c, a);
        tick();
      end
    end
    for (int a = 0; a < 16; a++) begin
      w3_en = 1'b1; w3_addr = {CB3'(3), AB3'(a)}; w3_data = 16'hDEAD;
      tick();
    end
    w3_en = 1'b0; w3_swap = 1'b1; w3_fs = 1'b1;
    tick();
    idle();
    check("ch3_front", f3_front, 1'b1);
    for (int a = 0; a < 16; a++) begin
      r3_en = 1'b1; r3_addr = AB3'(a);
      tick();
      r3_en = 1'b0;
      exp3 = {pat3(2, a), pat3(1, a), pat3(0, a)};
      check("ch3_dropped", r3_data, {16'h0, exp3});
    end

    tick();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
